// File: rtl/sat_chan_pkg.sv
// Shared types and constants for the sat_chan channel bank and its
// configuration scheduler.
package sat_chan_pkg;

  localparam int NUM_CA_SEQ = 36;
  localparam int FREQ_W     = 32;
  localparam int GAIN_W     = 16;
  localparam int CA_SEL_W   = 6;

  typedef enum logic [1:0] {
    FREQ   = 2'd0,
    GAIN   = 2'd1,
    CA_SEL = 2'd2,
    ENABLE = 2'd3
  } cfg_field_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } sched_state_t;

  // Only codes 0..NUM_CA_SEQ-1 name a real C/A sequence.
  function automatic logic ca_sel_ok(input logic [CA_SEL_W-1:0] sel);
    return int'(sel) < NUM_CA_SEQ;
  endfunction

endpackage

// File: rtl/sat_chan_cfg_slot.sv
// One channel's shadow/active configuration pair; a commit copies the whole
// shadow set to active in one clock, but only if a write is pending.
module sat_chan_cfg_slot
  import sat_chan_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  cfg_field_t          field,
  input  logic [FREQ_W-1:0]   data,
  input  logic                commit,
  output logic [FREQ_W-1:0]   act_freq,
  output logic [GAIN_W-1:0]   act_gain,
  output logic [CA_SEL_W-1:0] act_ca_sel,
  output logic                act_enable,
  output logic                pending
);

  logic [FREQ_W-1:0]   sh_freq;
  logic [GAIN_W-1:0]   sh_gain;
  logic [CA_SEL_W-1:0] sh_ca_sel;
  logic                sh_enable;

  // Writes are stalled during the commit cycle, so commit and wr_en never overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_freq    <= '0;
      sh_gain    <= '0;
      sh_ca_sel  <= '0;
      sh_enable  <= 1'b0;
      act_freq   <= '0;
      act_gain   <= '0;
      act_ca_sel <= '0;
      act_enable <= 1'b0;
      pending    <= 1'b0;
    end else if (commit && pending) begin
      act_freq   <= sh_freq;
      act_gain   <= sh_gain;
      act_ca_sel <= sh_ca_sel;
      act_enable <= sh_enable;
      pending    <= 1'b0;
    end else if (wr_en) begin
      case (field)
        FREQ:    sh_freq   <= data;
        GAIN:    sh_gain   <= data[GAIN_W-1:0];
        CA_SEL:  sh_ca_sel <= data[CA_SEL_W-1:0];
        default: sh_enable <= data[0];
      endcase
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/sat_chan_sched.sv
// Epoch-aligned configuration scheduler: host writes land in shadow registers
// and are promoted to all channels together on the first epoch after arming.
module sat_chan_sched
  import sat_chan_pkg::*;
#(
  parameter int NUM_CHAN = 8,
  parameter int CHAN_W   = $clog2(NUM_CHAN)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [CHAN_W-1:0]            wr_chan,
  input  logic [1:0]                   wr_field,
  input  logic [31:0]                  wr_data,
  output logic                         wr_err,
  input  logic                         commit_req,
  input  logic                         epoch,
  output logic                         commit_busy,
  output logic                         commit_done,
  output logic [NUM_CHAN-1:0]          pending,
  output logic [NUM_CHAN*FREQ_W-1:0]   ch_freq,
  output logic [NUM_CHAN*GAIN_W-1:0]   ch_gain,
  output logic [NUM_CHAN*CA_SEL_W-1:0] ch_ca_sel,
  output logic [NUM_CHAN-1:0]          ch_enable
);

  sched_state_t state;
  logic         wr_fire;
  logic         wr_drop;
  logic         in_commit;

  assign in_commit   = (state == COMMIT);
  assign wr_ready    = !in_commit;
  assign commit_busy = (state != IDLE);
  assign wr_fire     = wr_valid & wr_ready;

  // Dropped writes still complete the handshake; they only raise wr_err.
  assign wr_drop = (int'(wr_chan) >= NUM_CHAN) ||
                   ((cfg_field_t'(wr_field) == CA_SEL) && !ca_sel_ok(wr_data[CA_SEL_W-1:0]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_err      <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      wr_err      <= wr_fire & wr_drop;
      commit_done <= in_commit;
      case (state)
        IDLE:    if (commit_req) state <= ARMED;
        ARMED:   if (epoch)      state <= COMMIT;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_slot
    sat_chan_cfg_slot u_slot (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_fire && !wr_drop && (wr_chan == CHAN_W'(i))),
      .field      (cfg_field_t'(wr_field)),
      .data       (wr_data),
      .commit     (in_commit),
      .act_freq   (ch_freq[FREQ_W*i +: FREQ_W]),
      .act_gain   (ch_gain[GAIN_W*i +: GAIN_W]),
      .act_ca_sel (ch_ca_sel[CA_SEL_W*i +: CA_SEL_W]),
      .act_enable (ch_enable[i]),
      .pending    (pending[i])
    );
  end

endmodule

// File: doc/sat_chan_sched.md
# sat_chan_sched

Configuration scheduler for the bank of `sat_chan` instances in the GPS synthesizer. It accepts host writes of Doppler frequency, gain, C/A select and enable into per-channel shadow registers. On an armed C/A epoch strobe it atomically copies every pending shadow value into the active registers that drive the channels. The result is that all SVs change parameters on the same clock, aligned to a code epoch, with no glitches mid-chip.

## Interface
Parameters:
- `NUM_CHAN`, 8: number of `sat_chan` instances served.
- `CHAN_W`, `$clog2(NUM_CHAN)`: channel index width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  host write request.
- `wr_ready`  out  1  write accepted when `wr_valid & wr_ready`.
- `wr_chan`  in  CHAN_W  target channel.
- `wr_field`  in  2  field select: 0 = FREQ, 1 = GAIN, 2 = CA_SEL, 3 = ENABLE.
- `wr_data`  in  32  FREQ uses [31:0], GAIN uses [15:0], CA_SEL uses [5:0], ENABLE uses [0].
- `wr_err`  out  1  one-cycle pulse when an accepted write was dropped.
- `commit_req`  in  1  one-cycle arm request.
- `epoch`  in  1  one-cycle C/A epoch strobe (1 ms).
- `commit_busy`  out  1  high in ARMED and COMMIT.
- `commit_done`  out  1  one-cycle pulse; coincides with the first cycle new active values are visible.
- `pending`  out  NUM_CHAN  per-channel flag: shadow differs from active because of a write since the last commit.
- `ch_freq`  out  NUM_CHAN*32  active frequency; channel i occupies [32*i +: 32].
- `ch_gain`  out  NUM_CHAN*16  active gain.
- `ch_ca_sel`  out  NUM_CHAN*6  active C/A select.
- `ch_enable`  out  NUM_CHAN  active enable.

## Operation
- FSM states:
  - IDLE: `commit_req` moves to ARMED.
  - ARMED: `epoch` moves to COMMIT.
  - COMMIT: lasts exactly one cycle, then returns to IDLE.
- COMMIT action: for every channel with `pending[i]=1`, copy all four shadow fields to active and clear `pending[i]`. Non-pending channels are untouched.
- A COMMIT with zero pending channels still occurs and still pulses `commit_done`.
- `wr_ready = (state != COMMIT)`. Writes are stalled only during the COMMIT cycle.
- An accepted write updates the addressed shadow field and sets `pending[wr_chan]`.
- Writes accepted in ARMED, including on the `epoch` cycle itself, are part of the upcoming commit.
- Dropped writes are still accepted (the handshake completes), pulse `wr_err` on the next cycle, and leave shadow and `pending` unchanged. A write is dropped when:
  - `wr_chan >= NUM_CHAN`, or
  - the field is CA_SEL and `wr_data[5:0] > 35`.
- `commit_req` is ignored in ARMED and COMMIT. Re-arming is not queued.
- `commit_req` and `epoch` together in IDLE: the block arms only; the commit waits for the next epoch.
- `epoch` in IDLE is ignored.
- Reset, which may arrive mid-ARMED or mid-COMMIT, forces the following values. No partial copy survives.
  - State: IDLE.
  - Shadow and active registers, `pending`, `wr_err`, `commit_done`: all 0.
  - `wr_ready`: 1.
  - `commit_busy`: 0.

## Timing
- Write accepted at edge N: shadow and `pending` update at N; `wr_err` is high in cycle N+1.
- `epoch` high in cycle N while ARMED:
  - cycle N+1: COMMIT (`wr_ready=0`, `commit_busy=1`);
  - cycle N+2: new `ch_*` values visible, `commit_done=1`, `pending` cleared, state IDLE, `commit_busy=0`.
- Total epoch-to-output latency: 2 cycles.
- All outputs are registered, except `wr_ready` and `commit_busy`, which are decoded directly from the state register.
- Back-to-back writes sustain 1 per cycle outside COMMIT.

## Structure
- Shared package `sat_chan_pkg`:
  - `cfg_field_t` enum (FREQ/GAIN/CA_SEL/ENABLE);
  - `NUM_CA_SEQ = 36`;
  - widths `FREQ_W = 32`, `GAIN_W = 16`, `CA_SEL_W = 6`;
  - `sched_state_t` (IDLE/ARMED/COMMIT).
- One sub-module, `sat_chan_cfg_slot`, instantiated NUM_CHAN times. It holds one channel's shadow, active and pending registers, with inputs `wr_en`, `field`, `data` and `commit`.
- The top level holds the FSM, address decode and range check.

## Test plan
- Reset, then write FREQ=0x0001_0000 to ch 2 -> `pending=0x04` and `ch_freq[2]` still 0. Then `commit_req`, and `epoch` 10 cycles later -> `ch_freq[2]=0x0001_0000` exactly 2 cycles after `epoch`, with `commit_done` in the same cycle and `pending=0`.
- Write CA_SEL=36 to ch 0 -> `wr_err` pulse one cycle later and `pending[0]=0`. Write CA_SEL=35 -> accepted and `pending[0]=1`.
- Arm, then issue a write to ch 5 on the `epoch` cycle -> the value is included in the commit. Hold `wr_valid` through COMMIT -> `wr_ready=0` for exactly 1 cycle and the held write lands after it, setting `pending[5]` again.
- `commit_req` together with `epoch` in IDLE -> no commit. Next `epoch` -> commit.
- Write gain to ch 1, arm, then assert `reset` one cycle after `epoch` -> all `ch_*`=0, `pending`=0, no `commit_done`.
- Commit with nothing pending -> `commit_done` still pulses and all outputs are unchanged.
